// File: rtl/pwm_pkg.sv
// pwm_pkg: shared width, reset constants and the {duty, top} configuration record
package pwm_pkg;
    localparam int PWM_WIDTH = 8;
    typedef struct packed {
        logic [PWM_WIDTH-1:0] duty;
        logic [PWM_WIDTH-1:0] top;
    } pwm_cfg_t;
    localparam logic [PWM_WIDTH-1:0] DUTY_RST = '0;
    localparam logic [PWM_WIDTH-1:0] TOP_RST  = '1;
    localparam pwm_cfg_t CFG_RST = '{duty: DUTY_RST, top: TOP_RST};
endpackage

// File: rtl/pwm_shadow.sv
// pwm_shadow: shadow/active configuration pair, update-pending flag and update acknowledge
// Ports: ck/rst clock and sync reset; en_i run enable; wr_i write strobe with cfg_i;
//        apply_i period wrap; act_o active config; pend_o pending flag; upd_ack_o ack pulse
module pwm_shadow
    import pwm_pkg::*;
(
    input  logic     ck,
    input  logic     rst,
    input  logic     en_i,
    input  logic     wr_i,
    input  logic     apply_i,
    input  pwm_cfg_t cfg_i,
    output pwm_cfg_t act_o,
    output logic     pend_o,
    output logic     upd_ack_o
);
    pwm_cfg_t sh_q, sh_d, act_q, act_d;
    logic     pend_q, pend_d, ack_pre_q, ack_pre_d, ack_q;
    logic     do_apply;

    // The ack is delayed two edges so it lines up with the first output sample
    // produced from the new active values.
    always_comb begin
        do_apply  = apply_i && pend_q;
        sh_d      = wr_i ? cfg_i : sh_q;
        act_d     = (!en_i && wr_i) ? cfg_i : do_apply ? sh_q : act_q;
        pend_d    = en_i ? (wr_i || (pend_q && !apply_i)) : (pend_q && !wr_i);
        ack_pre_d = en_i ? do_apply : wr_i;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            sh_q      <= CFG_RST;
            act_q     <= CFG_RST;
            pend_q    <= 1'b0;
            ack_pre_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            act_q     <= act_d;
            pend_q    <= pend_d;
            ack_pre_q <= ack_pre_d;
            ack_q     <= ack_pre_q;
        end
    end

    assign act_o     = act_q;
    assign pend_o    = pend_q;
    assign upd_ack_o = ack_q;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: programmable-period PWM generator with shadowed duty/period updates
// Ports: ck/rst clock and sync reset; en run enable; duty_in/top_in/wr shadow write;
//        pwm_d registered PWM level; cyc_start period marker; upd_ack update ack; pend pending flag
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] top_in,
    input  logic             wr,
    output logic             pwm_d,
    output logic             cyc_start,
    output logic             upd_ack,
    output logic             pend
);
    pwm_cfg_t         cfg_in, act;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d, cyc_q, cyc_d, wrap;

    assign cfg_in = '{duty: duty_in, top: top_in};

    always_comb begin
        wrap  = en && (cnt_q == act.top);
        cnt_d = (!en || wrap) ? '0 : cnt_q + 1'b1;
        lvl_d = en && (cnt_q < act.duty);
        cyc_d = en && (cnt_q == '0);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
            cyc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            cyc_q <= cyc_d;
        end
    end

    pwm_shadow u_shadow (
        .ck        (ck),
        .rst       (rst),
        .en_i      (en),
        .wr_i      (wr),
        .apply_i   (wrap),
        .cfg_i     (cfg_in),
        .act_o     (act),
        .pend_o    (pend),
        .upd_ack_o (upd_ack)
    );

    assign pwm_d     = lvl_q;
    assign cyc_start = cyc_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: vector table, corner sequences and randomized run against a period-level model
module tb_pwm_gen;
    logic       ck, rst, en, wr;
    logic [7:0] duty_in, top_in;
    logic       pwm_d, cyc_start, upd_ack, pend;

    pwm_gen #(.WIDTH(8)) dut (
        .ck(ck), .rst(rst), .en(en), .duty_in(duty_in), .top_in(top_in), .wr(wr),
        .pwm_d(pwm_d), .cyc_start(cyc_start), .upd_ack(upd_ack), .pend(pend)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // model: phase within period, active/shadow settings, pending flag, ack delay line
    int m_p = 0, m_ad = 0, m_at = 255, m_sd = 0, m_st = 255;
    int m_pend = 0, m_ack1 = 0, m_ack2 = 0, m_pwm = 0, m_cyc = 0;

    typedef struct {
        bit       r, e, w;
        bit [7:0] d, t;
        bit       p, c, a, n;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, e, w, input int d, t);
        int hi;
        if (r) begin
            m_p = 0; m_ad = 0; m_at = 255; m_sd = 0; m_st = 255;
            m_pend = 0; m_ack1 = 0; m_ack2 = 0; m_pwm = 0; m_cyc = 0;
        end else begin
            hi     = (m_ad < m_at + 1) ? m_ad : m_at + 1;
            m_pwm  = (e && m_p < hi) ? 1 : 0;
            m_cyc  = (e && m_p == 0) ? 1 : 0;
            m_ack2 = m_ack1;
            if (e) begin
                m_ack1 = (m_p == m_at && m_pend != 0) ? 1 : 0;
                if (m_p == m_at) begin
                    m_p = 0;
                    if (m_pend != 0) begin
                        m_ad = m_sd; m_at = m_st; m_pend = 0;
                    end
                end else m_p++;
                if (w) begin
                    m_sd = d; m_st = t; m_pend = 1;
                end
            end else begin
                m_p    = 0;
                m_ack1 = w ? 1 : 0;
                if (w) begin
                    m_ad = d; m_at = t; m_sd = d; m_st = t; m_pend = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, e, w, input bit [7:0] d, t);
        rst = r; en = e; wr = w; duty_in = d; top_in = t;
        @(posedge ck);
        model_edge(r, e, w, int'(d), int'(t));
        #1;
        chk("pwm_d", int'(pwm_d), m_pwm);
        chk("cyc_start", int'(cyc_start), m_cyc);
        chk("upd_ack", int'(upd_ack), m_ack2);
        chk("pend", int'(pend), m_pend);
    endtask

    task automatic to_phase(input int k);
        for (int i = 0; i < 300 && m_p != k; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic run_count(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0);
            hi += int'(pwm_d);
        end
    endtask

    initial begin
        int hi;
        rst = 1; en = 0; wr = 0; duty_in = 0; top_in = 0;
        tbl[0]  = '{1, 1, 1, 8'h55, 8'h66, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 8'h55, 8'h66, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 8'h55, 8'h66, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 8'd3, 8'd9, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 8'd0, 8'd0, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'd0, 8'd0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 8'd0, 8'd0, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 8'd7, 8'd9, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 1};
        tbl[14] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 8'd0, 8'd0, 1, 1, 1, 0};
        tbl[16] = '{0, 1, 0, 8'd0, 8'd0, 1, 0, 0, 0};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].d, tbl[i].t);
            chk($sformatf("vec%0d_pwm", i), int'(pwm_d), int'(tbl[i].p));
            chk($sformatf("vec%0d_cyc", i), int'(cyc_start), int'(tbl[i].c));
            chk($sformatf("vec%0d_ack", i), int'(upd_ack), int'(tbl[i].a));
            chk($sformatf("vec%0d_pend", i), int'(pend), int'(tbl[i].n));
        end

        // write on the wrap: pending duty 2 applied first, duty 5 one period later
        to_phase(4);
        step(0, 1, 1, 8'd2, 8'd9);
        to_phase(9);
        step(0, 1, 1, 8'd5, 8'd9);
        chk("wrap_wr_pend", int'(pend), 1);
        run_count(10, hi);
        chk("wrap_first_hi", hi, 2);
        run_count(10, hi);
        chk("wrap_second_hi", hi, 5);

        // two writes in one period: last wins
        to_phase(2);
        step(0, 1, 1, 8'd4, 8'd9);
        step(0, 1, 1, 8'd6, 8'd9);
        to_phase(0);
        run_count(10, hi);
        chk("last_write_hi", hi, 6);

        // duty limits
        step(0, 0, 1, 8'd0, 8'd9);
        run_count(20, hi);
        chk("duty0_hi", hi, 0);
        step(0, 0, 1, 8'd12, 8'd9);
        run_count(20, hi);
        chk("duty_over_top_hi", hi, 20);
        step(0, 0, 1, 8'd255, 8'd255);
        run_count(256, hi);
        chk("duty255_hi", hi, 255);

        // enable drop mid-period and restart
        step(0, 0, 1, 8'd3, 8'd9);
        to_phase(5);
        step(0, 0, 0, 0, 0);
        chk("en_drop_pwm", int'(pwm_d), 0);
        step(0, 1, 0, 0, 0);
        chk("en_rise_cyc", int'(cyc_start), 1);
        chk("en_rise_pwm", int'(pwm_d), 1);

        // reset mid-period with an update pending
        step(0, 1, 1, 8'd8, 8'd9);
        to_phase(5);
        chk("pre_rst_pend", int'(pend), 1);
        step(1, 1, 1, 8'd8, 8'd9);
        chk("rst_mid_pwm", int'(pwm_d), 0);
        chk("rst_mid_cyc", int'(cyc_start), 0);
        chk("rst_mid_pend", int'(pend), 0);
        run_count(20, hi);
        chk("post_rst_hi", hi, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                 8'($urandom_range(0, 17)), 8'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_gen.md
# pwm_gen

Programmable-period PWM generator that forms the raw PWM level for the output stage. Its registered `pwm_d` output drives the `d` input of the downstream single-bit output flip-flop, which retimes it onto the pin. Duty and period are written through shadow registers. New values take effect only at a period boundary, so no runt or stretched pulses occur.

## Interface
- `WIDTH`, 8: counter, duty and period width.
- `ck` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. When low, the counter is idle and the output is low.
- `duty_in` in WIDTH: requested high time, in ck cycles per period.
- `top_in` in WIDTH: requested period minus 1.
- `wr` in 1: one-cycle strobe. Captures `duty_in` and `top_in` into the shadow registers.
- `pwm_d` out 1: registered PWM level; feeds the output flip-flop.
- `cyc_start` out 1: registered pulse, aligned with the first `pwm_d` sample of each period.
- `upd_ack` out 1: one-cycle pulse, asserted the cycle after shadow values become active.
- `pend` out 1: high while shadow values are waiting to be applied.

## Operation
- Internal state:
  - `cnt`: WIDTH-bit period counter.
  - `duty_act` and `top_act`: active duty and period.
  - `duty_sh` and `top_sh`: shadow duty and period.
  - `pend`: update-pending flag.
- Reset (`rst`=1) values:
  - `cnt`=0, `duty_act`=0, `duty_sh`=0.
  - `top_act` and `top_sh` = all ones.
  - `pend`=0, `pwm_d`=0, `cyc_start`=0, `upd_ack`=0.
- Reset wins over every other input, including a reset asserted mid-period.
- Idle behaviour (`en`=0):
  - `cnt` is held at 0; `pwm_d` and `cyc_start` are 0.
  - A `wr` loads `duty_act` and `top_act` directly, and also the shadows. `pend` stays 0 and `upd_ack` pulses.
- Run behaviour (`en`=1):
  - Counting: if `cnt==top_act`, then `cnt` wraps to 0; otherwise `cnt` increments by 1.
  - Output: `pwm_d` <= (`cnt` < `duty_act`), an unsigned compare.
  - Cycle marker: `cyc_start` <= (`cnt`==0).
  - Write: a `wr` loads the shadows and sets `pend`.
  - Apply: at a wrap with `pend`=1, `duty_act`<=`duty_sh`, `top_act`<=`top_sh`, `pend` is cleared and `upd_ack` pulses next cycle.
- Write on a wrap cycle (`wr` and wrap together):
  - The apply uses the old shadow values.
  - The new write lands in the shadows, and `pend` stays 1 for the next wrap.
- Duty limits:
  - `duty_act`=0 gives an output that is always low.
  - `duty_act` > `top_act` gives an output that is always high.
  - With `top_act` all ones, the maximum duty is (2^WIDTH − 1)/2^WIDTH.
- Consecutive writes before a wrap: the last write wins.
- Falling `en`: `cnt` returns to 0 on the next edge. The active and shadow values are kept. `pend` is kept, and the pending values are applied at the next wrap after `en` rises. A `wr` while idle applies immediately (see Idle behaviour) and clears `pend`.

## Timing
- Period is `top_act`+1 cycles; high time is min(`duty_act`, `top_act`+1) cycles.
- `pwm_d` lags `cnt` by 1 cycle. Through the downstream flip-flop, the pin lags by 2 cycles.
- Enable start-up: `cnt` increments on the edge where `en` is first seen high. `pwm_d` and `cyc_start` reflect `cnt`=0 one cycle later, so `cyc_start` pulses then.
- Write to effect: `pwm_d` uses the new duty starting with the first sample after the wrap. That sample is the same cycle `cyc_start` and `upd_ack` are high.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `pwm_pkg`: default `WIDTH`, the reset constants for `top` (all ones) and `duty` (0), and a struct type {duty, top} used for both the active and shadow sets.
- Optional sub-module `pwm_shadow`: holds the shadow/active register pair, `pend` and `upd_ack`, and takes an `apply` input. The top level keeps the counter and compare.
- Target size: about 150–250 RTL lines.

## Test plan
- Reset: hold `rst` 3 cycles with `en`=1 and `wr`=1 → all outputs 0, `pend`=0; after release `pwm_d` stays 0 (`duty_act`=0).
- Basic run: with `en`=0, write duty=3 and top=9, then `en`=1 → `pwm_d` repeats 3 high / 7 low. `cyc_start` pulses every 10 cycles, aligned with the first high sample.
- Shadow update: running at duty=3, top=9, write duty=7 mid-period → `pend`=1 until the wrap. The next period is 7 high / 3 low, and `upd_ack` pulses alongside `cyc_start`.
- Write on the wrap: writes of duty=5 on the wrap cycle (`cnt`==9) → the current shadow is applied, then duty=5 is applied one period later. Two writes (4 then 6) within one period → only 6 is applied.
- Limits: duty=0 → `pwm_d` constantly 0. duty=12 with top=9 → constantly 1. top=255, duty=255 → 255 high / 1 low.
- Enable and reset mid-period: drop `en` at `cnt`=5 → `pwm_d`=0 next cycle and `cnt` restarts at 0 on re-enable. Assert `rst` at `cnt`=5 with `pend`=1 → all state returns to reset values.
